fb_write_arbiter: RTL
=====================

Name: fb_write_arbiter

Overview:
- Owns the write port of the 640x480, 2-bit-per-pixel dual-port frame buffer.
- Shares that port between two pixel-write requesters: A (drawing engine) and B (host/CPU path).
- Contains a full-frame clear sequencer that sweeps every address at one write per cycle.
- The frame buffer read port is not touched; scan-out continues during clears.

Parameters:
- ADDR_W, 19, frame buffer address width.
- DATA_W, 2, pixel width.
- DEPTH, 307200, number of valid pixel addresses (0..DEPTH-1).
- CLEAR_VAL, 2'b00, pixel value written by a clear when FB_CLR_VALUE_EN is off.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  requester A write valid; held until granted.
- a_addr  in  ADDR_W  requester A pixel address.
- a_data  in  DATA_W  requester A pixel value.
- a_gnt  out  1  combinational accept for A; the transfer completes in any cycle with a_req&a_gnt.
- b_req  in  1  requester B write valid.
- b_addr  in  ADDR_W  requester B pixel address.
- b_data  in  DATA_W  requester B pixel value.
- b_gnt  out  1  combinational accept for B.
- clr_start  in  1  single-cycle pulse that starts a full-frame clear.
- clr_busy  out  1  high while the clear sweep is running.
- clr_done  out  1  one-cycle pulse after the sweep ends.
- drop_cnt  out  8  saturating count of accepted writes with address >= DEPTH.
- fb_we  out  1  registered frame buffer write enable.
- fb_wr_addr  out  ADDR_W  registered frame buffer write address.
- fb_wrt_data  out  DATA_W  registered frame buffer write data.

Behaviour:
- Reset values:
  - fb_we=0, fb_wr_addr=0, fb_wrt_data=0.
  - clr_busy=0, clr_done=0, drop_cnt=0.
  - FSM=IDLE, clear counter=0, last_grant=B (so A wins the first contention).
- FSM states:
  - IDLE: clr_start -> CLEAR. Requesters are serviced.
  - CLEAR: issues one write per cycle at counter address k with the clear value; k runs 0..DEPTH-1. When k=DEPTH-1 is issued -> DONE. a_gnt=b_gnt=0 throughout. clr_busy=1.
  - DONE: one cycle; clr_done=1; requesters are serviced; next state IDLE.
- Clear has absolute priority. A clr_start seen in IDLE takes effect that cycle: no grant is given in that cycle.
- clr_start while in CLEAR or DONE is ignored; it is not queued.
- Arbitration (IDLE/DONE):
  - Only one requester active: grant it that cycle.
  - Both active: grant the one not equal to last_grant.
  - last_grant updates only on a completed grant.
  - At most one grant per cycle.
- Latency: a write accepted, or a clear address issued, in cycle N appears on fb_we/fb_wr_addr/fb_wrt_data in cycle N+1. fb_we=1 for exactly one cycle per write.
- Throughput: one write per cycle. There are no bubbles between back-to-back grants or clear addresses.
- Out-of-range write (accepted address >= DEPTH):
  - The grant is still given, so the requester is not deadlocked.
  - fb_we stays 0 for that write.
  - drop_cnt increments and saturates at 255.
- Clear duration is exactly DEPTH cycles of fb_we=1, with addresses strictly ascending 0..DEPTH-1. The counter compares against DEPTH-1, never wraps, and never issues address DEPTH.
- Reset mid-clear aborts immediately: state IDLE, counter 0, no clr_done pulse. Frame buffer contents are left partially cleared.
- A requester that deasserts req without a grant is permitted; nothing is recorded.

Optional Feature:
- Macro: FB_CLR_VALUE_EN.
- Defined:
  - Adds input port clr_value [DATA_W-1:0].
  - clr_value is latched on the accepted clr_start, and that latched value is written to every address of the sweep.
  - Changes on clr_value during CLEAR have no effect.
- Undefined: no clr_value port; the clear writes CLEAR_VAL.

Test Plan:
- Reset, then a_req=1, a_addr=100, a_data=2'b11 for one cycle -> a_gnt=1 the same cycle; next cycle fb_we=1, fb_wr_addr=100, fb_wrt_data=2'b11; the following cycle fb_we=0.
- a_req and b_req both held for 4 cycles with distinct addresses -> grants A,B,A,B; fb outputs show the four addresses in that order on consecutive cycles.
- clr_start pulse in IDLE:
  - clr_busy=1 for 307200 cycles; fb_we=1 with addresses 0..307199 ascending and data 2'b00.
  - Then clr_done=1 for one cycle; clr_busy=0 afterwards.
- a_req held while a clear runs -> a_gnt=0 for the whole sweep; the grant is given in the DONE cycle; the A write appears on the next cycle.
- b_req with b_addr=307200 (three times) -> b_gnt=1 each time, fb_we stays 0, drop_cnt=3. Forcing 300 drops -> drop_cnt=255.
- rst asserted at clear address 5000 -> the next cycle shows fb_we=0, clr_busy=0, no clr_done. With FB_CLR_VALUE_EN and clr_value=2'b10 at clr_start, every cleared address is written 2'b10.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Write-port owner for the 2bpp frame buffer: arbitrates two pixel writers and runs a full-frame clear.
// Optional FB_CLR_VALUE_EN adds a clr_value input latched when a clear starts.
module fb_write_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 2,
  parameter int DEPTH  = 307200,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  input  logic              clr_start,
`ifdef FB_CLR_VALUE_EN
  input  logic [DATA_W-1:0] clr_value,
`endif
  output logic              clr_busy,
  output logic              clr_done,
  output logic [7:0]        drop_cnt,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [DATA_W-1:0] fb_wrt_data
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              last_b_q, last_b_d;
  logic [7:0]        drop_q, drop_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] fill_val;
  logic              serve;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

`ifdef FB_CLR_VALUE_EN
  logic [DATA_W-1:0] clr_val_q, clr_val_d;
  assign fill_val = clr_val_q;
`else
  assign fill_val = CLEAR_VAL;
`endif

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    last_b_d  = last_b_q;
    drop_d    = drop_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    serve     = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
`ifdef FB_CLR_VALUE_EN
    clr_val_d = clr_val_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A clear request pre-empts any grant in the same cycle.
        if (clr_start) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
`ifdef FB_CLR_VALUE_EN
          clr_val_d = clr_value;
`endif
        end else begin
          serve = 1'b1;
        end
      end
      S_CLEAR: begin
        clr_busy = 1'b1;
        we_d     = 1'b1;
        addr_d   = clr_cnt_q;
        data_d   = fill_val;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = S_DONE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        clr_done = 1'b1;
        serve    = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (serve) begin
      // On contention the requester that did not win last time goes first.
      if (a_req && (!b_req || last_b_q)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end

    if (a_gnt || b_gnt) begin
      sel_addr = a_gnt ? a_addr : b_addr;
      sel_data = a_gnt ? a_data : b_data;
      last_b_d = b_gnt;
      if ({1'b0, sel_addr} < DEPTH_EXT) begin
        we_d   = 1'b1;
        addr_d = sel_addr;
        data_d = sel_data;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clr_cnt_q <= '0;
      last_b_q  <= 1'b1;
      drop_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
`ifdef FB_CLR_VALUE_EN
      clr_val_q <= CLEAR_VAL;
`endif
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      last_b_q  <= last_b_d;
      drop_q    <= drop_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
`ifdef FB_CLR_VALUE_EN
      clr_val_q <= clr_val_d;
`endif
    end
  end

  assign drop_cnt    = drop_q;
  assign fb_we       = we_q;
  assign fb_wr_addr  = addr_q;
  assign fb_wrt_data = data_q;

endmodule
